tea_key_match_tracker: RTL

- Downstream stage of the 32-stage pipelined TEA decryptor in the brute-force key search.
- Delays each candidate key by the decryptor's pipeline depth so the key lines up with its own decrypted block.
- Tests each decrypted block against the PDF header magic, captures the first matching key and counts attempts.
- Raises a sticky ready flag on a hit, or an exhausted flag when the key space has been covered.

---
 rtl/tea_key_match_tracker_if.sv | 23 ++
 rtl/tea_key_match_tracker.sv | 114 +++++++++++
 2 files changed

// File: rtl/tea_key_match_tracker_if.sv
// Bus between the TEA decryptor pipeline and the key match tracker.
// The master drives the key/plaintext stream; the slave reports search status.
interface tea_key_match_tracker_if;
   logic         ena;
   logic         clear;
   logic [127:0] key_in;
   logic [63:0]  plain_in;
   logic [127:0] found_key;
   logic [31:0]  attempts;
   logic         busy;
   logic         rdy;
   logic         exhausted;

   modport master (
      output ena, clear, key_in, plain_in,
      input  found_key, attempts, busy, rdy, exhausted
   );

   modport slave (
      input  ena, clear, key_in, plain_in,
      output found_key, attempts, busy, rdy, exhausted
   );
endinterface

// File: rtl/tea_key_match_tracker.sv
// Aligns candidate keys with decrypted blocks, checks for the PDF magic,
// captures the first hit and counts compared blocks.
module tea_key_match_tracker #(
   parameter int          PIPE_DEPTH   = 32,
   parameter logic [31:0] MAGIC        = 32'h25504446,
   parameter logic [31:0] MAGIC_MASK   = 32'hFFFFFFFF,
   parameter logic [31:0] MAX_ATTEMPTS = 32'h3FFFFFFF
) (
   input  logic                          clk,
   input  logic                          rst,
   tea_key_match_tracker_if.slave        bus
);

   typedef enum logic [2:0] {
      IDLE, FILL, SEARCH, FOUND, EXHAUSTED
   } state_e;

   state_e                state_q, state_d;
   logic [PIPE_DEPTH-1:0] vld_q, vld_d;
   logic [127:0]          key_q [PIPE_DEPTH];
   logic [127:0]          key_d [PIPE_DEPTH];
   logic [127:0]          found_q, found_d;
   logic [31:0]           att_q, att_d, att_inc;
   logic                  busy_q, busy_d;
   logic                  rdy_q, rdy_d;
   logic                  exh_q, exh_d;
   logic                  ins, tail_vld, hit, drained;
   logic                  unused_lo;

   assign unused_lo = ^bus.plain_in[31:0];

   always_comb begin
      ins = bus.ena & (state_q != FOUND) & (state_q != EXHAUSTED) & ~bus.clear;
      vld_d = {vld_q[PIPE_DEPTH-2:0], ins};
      key_d[0] = bus.key_in;
      for (int i = 1; i < PIPE_DEPTH; i++) key_d[i] = key_q[i-1];

      tail_vld = vld_q[PIPE_DEPTH-1];
      hit = tail_vld &
            ((bus.plain_in[63:32] & MAGIC_MASK) == (MAGIC & MAGIC_MASK));
      // Line is empty after this edge: nothing behind the tail, nothing entering.
      drained = ~ins & ~|vld_q[PIPE_DEPTH-2:0];
      att_inc = (att_q == 32'hFFFFFFFF) ? att_q : att_q + 32'd1;

      state_d = state_q;
      found_d = found_q;
      att_d   = att_q;

      unique case (state_q)
         IDLE: begin
            if (bus.ena) state_d = FILL;
         end
         FILL, SEARCH: begin
            if (tail_vld) begin
               att_d = att_inc;
               if (hit) begin
                  state_d = FOUND;
                  found_d = key_q[PIPE_DEPTH-1];
               end else if (att_inc == MAX_ATTEMPTS) begin
                  state_d = EXHAUSTED;
               end else if (drained) begin
                  state_d = IDLE;
               end else begin
                  state_d = SEARCH;
               end
            end else if (drained) begin
               state_d = IDLE;
            end
         end
         FOUND, EXHAUSTED: ;
         default: state_d = IDLE;
      endcase

      if (bus.clear) begin
         state_d = IDLE;
         vld_d   = '0;
         att_d   = '0;
         found_d = found_q;
      end

      busy_d = (state_d == FILL) | (state_d == SEARCH);
      rdy_d  = (state_d == FOUND);
      exh_d  = (state_d == EXHAUSTED);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         vld_q   <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) key_q[i] <= '0;
         found_q <= '0;
         att_q   <= '0;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b0;
         exh_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         for (int i = 0; i < PIPE_DEPTH; i++) key_q[i] <= key_d[i];
         found_q <= found_d;
         att_q   <= att_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
         exh_q   <= exh_d;
      end
   end

   assign bus.found_key = found_q;
   assign bus.attempts  = att_q;
   assign bus.busy      = busy_q;
   assign bus.rdy       = rdy_q;
   assign bus.exhausted = exh_q;

endmodule
